data_sram_like_slave: RTL and testbench
=======================================

Name: data_sram_like_slave

Overview:
- Data-side memory responder for the CPU's planned SRAM-like bus: request/addr_ok on the address phase, data_ok/rdata on the data phase.
- The Memory stage is the consumer of rdata.
- Holds a word-organised RAM with byte-lane write strobes and answers every accepted transaction, read or write, in order after a fixed, parameterised latency.
- Bounds the number of in-flight transactions.

Parameters:
- IDX_W, 10: word-index width; RAM holds 2^IDX_W 32-bit words.
- LATENCY, 2: cycles from acceptance edge to data_ok; legal 1..4.
- MAX_OUT, 2: maximum transactions accepted but not yet answered; legal 1..LATENCY.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- req  in  1  master presents a transaction this cycle.
- wr  in  1  1 = write, 0 = read.
- addr  in  32  byte address; word index = addr[IDX_W+1:2]; addr[1:0] and bits above IDX_W+1 ignored (aliasing).
- wstrb  in  4  byte enables for writes; bit i gates wdata[8i+7:8i]; ignored for reads.
- wdata  in  32  write data.
- addr_ok  out  1  slave can accept; transaction accepted on a rising edge where req && addr_ok.
- data_ok  out  1  one-cycle pulse: response for the oldest outstanding transaction.
- rdata  out  32  read data, valid only while data_ok is high.

Behaviour:
- Reset (rstn low, async):
  - addr_ok=1, data_ok=0, rdata=0.
  - Outstanding count=0; response delay line cleared.
  - RAM contents are not reset and are retained across reset.
- Reset mid-operation: all in-flight transactions are dropped with no data_ok. Writes already accepted before reset asserted remain in RAM.
- Acceptance:
  - addr_ok = (outstanding_count < MAX_OUT), purely from registered state; no combinational path from req.
  - A response retiring in the same cycle does not free the slot until the next cycle.
- Write:
  - On the acceptance edge, RAM word is updated bytewise per wstrb.
  - wstrb=0 is a legal no-op write and still receives data_ok.
- Read:
  - RAM word is sampled on the acceptance edge into the delay line.
  - The value is unaffected by any later write.
  - A read accepted on the edge after a write to the same word returns the new data.
- Response timing:
  - Transaction accepted on edge k drives data_ok=1 for exactly the cycle following edge k+LATENCY-1. With LATENCY=1 this is the cycle right after acceptance, matching the current single-cycle data_sram timing.
  - Responses are strictly in acceptance order; back-to-back acceptances produce back-to-back data_ok pulses.
- rdata:
  - Read response: the sampled word.
  - Write response: 0.
  - Cycles without data_ok: holds its last value (no meaning).
- No response backpressure: the master must take data_ok/rdata when presented.
- Outstanding counter:
  - +1 on accept, -1 on data_ok, unchanged when both occur on the same edge.
  - Never exceeds MAX_OUT and never underflows.
- Implementation: LATENCY-stage shift line of {valid, data}; data_ok = valid of the last stage.
- req=0: no state change except the delay line advancing. Inputs other than req are don't-care when req=0.

Test Plan:
- Reset, LATENCY=2, MAX_OUT=2:
  - Write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF.
  - Then read 0x10 -> write data_ok 2 cycles after its acceptance with rdata=0; read data_ok 2 cycles after its acceptance with rdata=0xDEADBEEF.
- Byte strobes:
  - Write 0x20=0x11223344 (wstrb 0xF), then write 0x20 wdata 0xAABBCCDD wstrb 0x5.
  - Then read -> rdata=0x11BB33DD; a write with wstrb 0x0 leaves it 0x11BB33DD.
- Back-pressure:
  - Hold req high with reads to 0x0, 0x4, 0x8 on consecutive cycles, LATENCY=2, MAX_OUT=1 -> addr_ok drops after each acceptance.
  - Exactly one outstanding at a time; three data_ok pulses, in order, none overlapping.
- Ordering/throughput:
  - LATENCY=2, MAX_OUT=2, preload words 0..3 with 0xA0..0xA3, then 4 consecutive reads.
  - data_ok pulses carry 0xA0, 0xA1, 0xA2, 0xA3 in order, with addr_ok low on the cycle after each second acceptance.
- Read-then-write hazard: read 0x30 (holds 0x5), then on the next edge write 0x30=0x9 -> read response returns 0x5; a subsequent read returns 0x9.
- Async reset mid-flight: accept two reads, assert rstn low between clock edges -> data_ok=0 and addr_ok=1 immediately. No stale data_ok after release; RAM contents preserved.

Source files
------------

// File: rtl/data_sram_like_slave.sv
// Data-side SRAM-like responder: word RAM with byte strobes, in-order responses.
// Latency: data_ok is high in the cycle after edge k+LATENCY-1 for a request accepted on edge k.
// Backpressure: addr_ok drops while MAX_OUT transactions are outstanding; responses cannot be stalled.
module data_sram_like_slave #(
    parameter int IDX_W   = 10,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int              CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    // Word-organised storage; deliberately has no reset so contents survive rstn.
    logic [31:0] mem_q [2**IDX_W];

    // Response delay line: one {valid, data} pair per latency stage.
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic [31:0]        dat_q [LATENCY];
    logic [31:0]        dat_d [LATENCY];

    // Transactions accepted but not yet answered.
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             unused_addr_bits;

    // Byte offset and high address bits alias onto the same word.
    assign idx              = addr[IDX_W+1:2];
    assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};

    // Acceptance depends only on the registered count, never on req.
    assign addr_ok = (cnt_q < MAX_CNT);
    assign accept  = req && addr_ok;

    assign data_ok = vld_q[LATENCY-1];
    assign rdata   = dat_q[LATENCY-1];

    // Bytewise RAM update on the acceptance edge of a write; nothing lands while held in reset.
    always_ff @(posedge clk) begin
        if (rstn && accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Delay line next state: stage 0 captures the read word (old value) or 0 for writes.
    // Data only moves alongside a valid bit, so the last stage keeps its last response value.
    always_comb begin
        vld_d[0] = accept;
        dat_d[0] = accept ? (wr ? 32'h0 : mem_q[idx]) : dat_q[0];
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    // Outstanding count: a slot freed by a retiring response only shows up next cycle.
    always_comb begin
        cnt_d = cnt_q;
        case ({accept, data_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset drops all in-flight responses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= 32'h0;
            end
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

endmodule

// File: tb/tb_data_sram_like_slave.sv
module tb_data_sram_like_slave;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        req0, wr0, addr_ok0, data_ok0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  wstrb0;
    logic        req1, wr1, addr_ok1, data_ok1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [3:0]  wstrb1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int          acc0[$];
    int          rcyc0[$];
    logic [31:0] rdat0[$];
    int          acc1[$];
    int          rcyc1[$];
    logic [31:0] rdat1[$];

    data_sram_like_slave #(.IDX_W(10), .LATENCY(2), .MAX_OUT(2)) u_dut0 (
        .clk(clk), .rstn(rstn), .req(req0), .wr(wr0), .addr(addr0), .wstrb(wstrb0),
        .wdata(wdata0), .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0)
    );

    data_sram_like_slave #(.IDX_W(10), .LATENCY(2), .MAX_OUT(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .req(req1), .wr(wr1), .addr(addr1), .wstrb(wstrb1),
        .wdata(wdata1), .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record acceptance edges and responses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rstn) begin
            if (req0 && addr_ok0) acc0.push_back(cyc + 1);
            if (data_ok0) begin rcyc0.push_back(cyc); rdat0.push_back(rdata0); end
            if (req1 && addr_ok1) acc1.push_back(cyc + 1);
            if (data_ok1) begin rcyc1.push_back(cyc); rdat1.push_back(rdata1); end
        end
    end

    task automatic clear_q();
        acc0.delete(); rcyc0.delete(); rdat0.delete();
        acc1.delete(); rcyc1.delete(); rdat1.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
    task automatic issue0(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int n = 0;
        req0 = 1'b1; wr0 = w; addr0 = a; wstrb0 = s; wdata0 = d;
        @(negedge clk);
        while (!addr_ok0 && n < 20) begin @(negedge clk); n++; end
        if (!addr_ok0) begin
            tests++; fails++;
            $display("FAIL issue0_timeout: addr_ok got %b want 1 within 20 cycles", addr_ok0);
        end
        @(posedge clk); #1;
        req0 = 1'b0;
    endtask

    task automatic issue1(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int n = 0;
        req1 = 1'b1; wr1 = w; addr1 = a; wstrb1 = s; wdata1 = d;
        @(negedge clk);
        while (!addr_ok1 && n < 20) begin @(negedge clk); n++; end
        if (!addr_ok1) begin
            tests++; fails++;
            $display("FAIL issue1_timeout: addr_ok got %b want 1 within 20 cycles", addr_ok1);
        end
        @(posedge clk); #1;
        req1 = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        tests++; if (addr_ok0 !== 1'b1) begin fails++; $display("FAIL reset_addr_ok0: got %b want 1", addr_ok0); end
        tests++; if (data_ok0 !== 1'b0) begin fails++; $display("FAIL reset_data_ok0: got %b want 0", data_ok0); end
        tests++; if (rdata0 !== 32'h0) begin fails++; $display("FAIL reset_rdata0: got %h want 0", rdata0); end
        tests++; if (addr_ok1 !== 1'b1) begin fails++; $display("FAIL reset_addr_ok1: got %b want 1", addr_ok1); end
        tests++; if (data_ok1 !== 1'b0) begin fails++; $display("FAIL reset_data_ok1: got %b want 0", data_ok1); end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        tests++; if (addr_ok0 !== 1'b1 || data_ok0 !== 1'b0) begin
            fails++; $display("FAIL post_reset_idle: addr_ok %b data_ok %b want 1 0", addr_ok0, data_ok0);
        end
    endtask

    task automatic test_write_read();
        clear_q();
        issue0(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        issue0(1'b0, 32'h10, 4'h0, 32'h0);
        settle();
        tests++;
        if (rcyc0.size() != 2 || acc0.size() != 2) begin
            fails++; $display("FAIL wr_rd_count: got %0d responses %0d accepts want 2 2", rcyc0.size(), acc0.size());
        end else begin
            tests++; if (acc0[1] != acc0[0] + 1) begin fails++; $display("FAIL wr_rd_b2b_accept: got gap %0d want 1", acc0[1] - acc0[0]); end
            tests++; if (rcyc0[0] != acc0[0] + 1) begin fails++; $display("FAIL wr_latency: got %0d want %0d", rcyc0[0], acc0[0] + 1); end
            tests++; if (rcyc0[1] != acc0[1] + 1) begin fails++; $display("FAIL rd_latency: got %0d want %0d", rcyc0[1], acc0[1] + 1); end
            tests++; if (rdat0[0] !== 32'h0) begin fails++; $display("FAIL wr_rdata: got %h want 00000000", rdat0[0]); end
            tests++; if (rdat0[1] !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_rdata: got %h want deadbeef", rdat0[1]); end
        end
    endtask

    task automatic test_strobes();
        logic [31:0] exp [5] = '{32'h0, 32'h0, 32'h11BB33DD, 32'h0, 32'h11BB33DD};
        clear_q();
        issue0(1'b1, 32'h20, 4'hF, 32'h11223344);
        issue0(1'b1, 32'h22, 4'h5, 32'hAABBCCDD);   // byte offset aliases to the same word
        issue0(1'b0, 32'h20, 4'h0, 32'h0);
        issue0(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF);
        issue0(1'b0, 32'h1020, 4'h0, 32'h0);          // high bits alias to the same word
        settle();
        tests++;
        if (rdat0.size() != 5) begin
            fails++; $display("FAIL strobe_count: got %0d want 5", rdat0.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (rdat0[i] !== exp[i]) begin fails++; $display("FAIL strobe_rdata[%0d]: got %h want %h", i, rdat0[i], exp[i]); end
            end
        end
    endtask

    task automatic test_ordering();
        logic [31:0] exp [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        int          gap [3] = '{1, 2, 1};
        for (int i = 0; i < 4; i++) issue0(1'b1, 32'(4 * i), 4'hF, exp[i]);
        settle();
        clear_q();
        issue0(1'b0, 32'h0, 4'h0, 32'h0);
        issue0(1'b0, 32'h4, 4'h0, 32'h0);
        tests++; if (addr_ok0 !== 1'b0) begin fails++; $display("FAIL order_full_after_2: addr_ok got %b want 0", addr_ok0); end
        issue0(1'b0, 32'h8, 4'h0, 32'h0);
        issue0(1'b0, 32'hC, 4'h0, 32'h0);
        tests++; if (addr_ok0 !== 1'b0) begin fails++; $display("FAIL order_full_after_4: addr_ok got %b want 0", addr_ok0); end
        settle();
        tests++;
        if (rdat0.size() != 4 || acc0.size() != 4) begin
            fails++; $display("FAIL order_count: got %0d responses %0d accepts want 4 4", rdat0.size(), acc0.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++; if (rdat0[i] !== exp[i]) begin fails++; $display("FAIL order_rdata[%0d]: got %h want %h", i, rdat0[i], exp[i]); end
                tests++; if (rcyc0[i] != acc0[i] + 1) begin fails++; $display("FAIL order_latency[%0d]: got %0d want %0d", i, rcyc0[i], acc0[i] + 1); end
            end
            for (int i = 0; i < 3; i++) begin
                tests++; if (acc0[i+1] - acc0[i] != gap[i]) begin fails++; $display("FAIL order_gap[%0d]: got %0d want %0d", i, acc0[i+1] - acc0[i], gap[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [3] = '{32'h1, 32'h2, 32'h3};
        for (int i = 0; i < 3; i++) issue1(1'b1, 32'(4 * i), 4'hF, exp[i]);
        settle();
        clear_q();
        for (int i = 0; i < 3; i++) begin
            issue1(1'b0, 32'(4 * i), 4'h0, 32'h0);
            tests++; if (addr_ok1 !== 1'b0) begin fails++; $display("FAIL bp_addr_ok_drop[%0d]: got %b want 0", i, addr_ok1); end
        end
        settle();
        tests++;
        if (rdat1.size() != 3 || acc1.size() != 3) begin
            fails++; $display("FAIL bp_count: got %0d responses %0d accepts want 3 3", rdat1.size(), acc1.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++; if (rdat1[i] !== exp[i]) begin fails++; $display("FAIL bp_rdata[%0d]: got %h want %h", i, rdat1[i], exp[i]); end
                tests++; if (rcyc1[i] != acc1[i] + 1) begin fails++; $display("FAIL bp_latency[%0d]: got %0d want %0d", i, rcyc1[i], acc1[i] + 1); end
            end
            for (int i = 0; i < 2; i++) begin
                tests++; if (acc1[i+1] - acc1[i] != 3) begin fails++; $display("FAIL bp_gap[%0d]: got %0d want 3", i, acc1[i+1] - acc1[i]); end
            end
        end
    endtask

    task automatic test_hazard();
        logic [31:0] exp [3] = '{32'h5, 32'h0, 32'h9};
        issue0(1'b1, 32'h30, 4'hF, 32'h5);
        settle();
        clear_q();
        issue0(1'b0, 32'h30, 4'h0, 32'h0);
        issue0(1'b1, 32'h30, 4'hF, 32'h9);
        issue0(1'b0, 32'h30, 4'h0, 32'h0);
        settle();
        tests++;
        if (rdat0.size() != 3 || acc0.size() != 3) begin
            fails++; $display("FAIL hazard_count: got %0d responses %0d accepts want 3 3", rdat0.size(), acc0.size());
        end else begin
            tests++; if (acc0[1] != acc0[0] + 1) begin fails++; $display("FAIL hazard_adjacent: got gap %0d want 1", acc0[1] - acc0[0]); end
            for (int i = 0; i < 3; i++) begin
                tests++; if (rdat0[i] !== exp[i]) begin fails++; $display("FAIL hazard_rdata[%0d]: got %h want %h", i, rdat0[i], exp[i]); end
            end
        end
    endtask

    task automatic test_async_reset();
        clear_q();
        issue0(1'b0, 32'h10, 4'h0, 32'h0);
        issue0(1'b0, 32'h20, 4'h0, 32'h0);
        tests++; if (data_ok0 !== 1'b1) begin fails++; $display("FAIL arst_pre_data_ok: got %b want 1", data_ok0); end
        #2; rstn = 1'b0; #1;
        tests++; if (data_ok0 !== 1'b0) begin fails++; $display("FAIL arst_data_ok: got %b want 0", data_ok0); end
        tests++; if (addr_ok0 !== 1'b1) begin fails++; $display("FAIL arst_addr_ok: got %b want 1", addr_ok0); end
        tests++; if (rdata0 !== 32'h0) begin fails++; $display("FAIL arst_rdata: got %h want 0", rdata0); end
        clear_q();
        repeat (2) @(posedge clk);
        #3; rstn = 1'b1;
        @(posedge clk); #1;
        settle();
        tests++; if (rcyc0.size() != 0) begin fails++; $display("FAIL arst_stale_data_ok: got %0d responses want 0", rcyc0.size()); end
        issue0(1'b0, 32'h10, 4'h0, 32'h0);
        issue0(1'b0, 32'h20, 4'h0, 32'h0);
        settle();
        tests++;
        if (rdat0.size() != 2) begin
            fails++; $display("FAIL arst_retain_count: got %0d want 2", rdat0.size());
        end else begin
            tests++; if (rdat0[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL arst_retain_10: got %h want deadbeef", rdat0[0]); end
            tests++; if (rdat0[1] !== 32'h11BB33DD) begin fails++; $display("FAIL arst_retain_20: got %h want 11bb33dd", rdat0[1]); end
        end
    endtask

    initial begin
        req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wstrb0 = '0; wdata0 = '0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wstrb1 = '0; wdata1 = '0;
        test_reset();
        test_write_read();
        test_strobes();
        test_ordering();
        test_backpressure();
        test_hazard();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
